// File: rtl/bias_fetch_ctrl.sv
// bias_fetch_ctrl: read-side controller for the packed bias SRAM.
// On an accepted start it reads packed words beginning at base_addr, unpacks
// BIAS_PER_ADDR signed lanes per word and streams one bias per beat, tagged with
// its channel index, over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle job request, accepted only in idle
//   base_addr, num_ch   job parameters, latched on an accepted start
//   busy, done          job in progress / 1-cycle end-of-job pulse
//   sram_csb            SRAM chip enable (active low), low only in the read cycle
//   sram_raddr          SRAM read address
//   sram_rdata          SRAM read data, valid the cycle after csb low
//   out_valid/out_ready bias beat handshake
//   out_bias, out_ch    current bias lane (raw two's complement) and its channel index
module bias_fetch_ctrl #(
  parameter int unsigned BIAS_PER_ADDR = 8,
  parameter int unsigned BW_PER_PARAM  = 8,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned DEPTH         = 45,
  parameter int unsigned CH_W          = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [ADDR_W-1:0]                     base_addr,
  input  logic [CH_W-1:0]                       num_ch,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sram_csb,
  output logic [ADDR_W-1:0]                     sram_raddr,
  input  logic [BIAS_PER_ADDR*BW_PER_PARAM-1:0] sram_rdata,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BW_PER_PARAM-1:0]               out_bias,
  output logic [CH_W-1:0]                       out_ch
);

  localparam int unsigned LaneW = (BIAS_PER_ADDR > 1) ? $clog2(BIAS_PER_ADDR) : 1;
  localparam int unsigned WordW = BIAS_PER_ADDR * BW_PER_PARAM;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StStream, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CH_W-1:0]    num_ch_q, num_ch_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [WordW-1:0]   word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      num_ch_q <= '0;
      ch_q     <= '0;
      lane_q   <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_ch_q <= num_ch_d;
      ch_q     <= ch_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    num_ch_d = num_ch_q;
    ch_d     = ch_q;
    lane_d   = lane_q;
    word_d   = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_ch != '0) begin
            addr_d   = base_addr;
            num_ch_d = num_ch;
            ch_d     = '0;
            lane_d   = '0;
            state_d  = StRead;
          end else begin
            // Empty job: report completion without touching the SRAM.
            state_d = StDone;
          end
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        word_d  = sram_rdata;
        state_d = StStream;
      end
      StStream: begin
        if (out_ready) begin
          if (ch_q == num_ch_q - CH_W'(1)) begin
            // Unused lanes of a partial last word are simply dropped.
            state_d = StDone;
          end else begin
            ch_d = ch_q + CH_W'(1);
            if (lane_q == LaneW'(BIAS_PER_ADDR - 1)) begin
              lane_d  = '0;
              addr_d  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
              state_d = StRead;
            end else begin
              lane_d = lane_q + LaneW'(1);
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs are decoded from registered state so reset takes effect immediately.
  assign busy       = (state_q == StRead) || (state_q == StWait) || (state_q == StStream);
  assign done       = (state_q == StDone);
  assign sram_csb   = (state_q != StRead);
  assign sram_raddr = addr_q;
  assign out_valid  = (state_q == StStream);
  assign out_ch     = ch_q;

  always_comb begin
    out_bias = word_q[lane_q*BW_PER_PARAM +: BW_PER_PARAM];
  end

endmodule
